icache_refill_arbiter: RTL and testbench
========================================

Name: icache_refill_arbiter

Overview:
- Arbitrates the single read channel of the I$ AXI shim between NumPorts refill requesters (port 0: L1I$ miss/bypass path; port 1: instruction prefetcher or ISPM fill engine).
- Holds each selected request stable until the shim grants it, as AXI requires.
- Tracks outstanding bursts per port and routes returning beats back to the owning port by AXI ID.
- Sits between the cache-side refill logic and the axi_shim rd_* interface.

Parameters:
- NumPorts, 2, number of requesters; must be a power of two and at least 2.
- AddrWidth, 64, physical address width.
- DataWidth, 64, AXI read data width.
- IdWidth, 4, AXI ID width; the upper PortBits = $clog2(NumPorts) bits carry the port index.
- TidWidth, IdWidth-PortBits, per-requester transaction ID width (derived; not overridable).
- BlenWidth, 2, burst length field width.
- MaxOutstanding, 2, maximum in-flight bursts per port; must be at least 1.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous reset, active-low
- req_i  in  NumPorts  per-port read request
- req_addr_i  in  NumPorts x AddrWidth  request address
- req_blen_i  in  NumPorts x BlenWidth  burst length minus 1
- req_size_i  in  NumPorts x 3  beat size
- req_tid_i  in  NumPorts x TidWidth  requester transaction ID
- req_gnt_o  out  NumPorts  one-hot grant
- rsp_valid_o  out  NumPorts  return beat valid for port p
- rsp_last_o  out  1  last beat (broadcast)
- rsp_data_o  out  DataWidth  beat data (broadcast)
- rsp_tid_o  out  TidWidth  requester TID of the beat (broadcast)
- rd_req_o  out  1  to shim rd_req_i
- rd_gnt_i  in  1  from shim rd_gnt_o
- rd_addr_o  out  AddrWidth  to shim
- rd_blen_o  out  BlenWidth  to shim
- rd_size_o  out  3  to shim
- rd_id_o  out  IdWidth  {port index, tid}
- rd_rdy_o  out  1  constant 1
- rd_valid_i  in  1  beat valid from shim
- rd_last_i  in  1  last beat of burst
- rd_data_i  in  DataWidth  beat data
- rd_id_i  in  IdWidth  beat ID
- busy_o  out  1  arbiter holding a request or any burst outstanding
- err_o  out  1  sticky: beat returned for a port with no outstanding burst

Behaviour:
- Reset:
  - State IDLE; round-robin pointer 0; all counters 0; err_o 0.
  - All outputs 0 except rd_rdy_o, which is 1.
- Eligibility: port p is eligible when req_i[p] is high and cnt[p] < MaxOutstanding.
- State IDLE:
  - If any port is eligible, select the first eligible port at or after the pointer, wrapping modulo NumPorts.
  - Drive rd_req_o and rd_* from the selected port's request combinationally, with rd_id_o = {p, req_tid_i[p]}.
  - If rd_gnt_i is high the same cycle: pulse req_gnt_o[p] and stay in IDLE.
  - Otherwise: latch p and go to HOLD.
- State HOLD:
  - Drive rd_* from the latched port only; all other ports are ignored.
  - The requester keeps its fields stable until granted.
  - On rd_gnt_i: pulse req_gnt_o[latched port] and return to IDLE.
  - A requester dropping req_i while in HOLD is a protocol violation; the arbiter keeps driving the request.
- Pointer update: on every grant, pointer becomes (granted port + 1) mod NumPorts.
- Grant latency: 0 cycles if the shim grants immediately.
- Counters, per port:
  - Increment on grant.
  - Decrement on rd_valid_i & rd_last_i when rd_id_i[IdWidth-1 -: PortBits] == p.
  - Simultaneous increment and decrement on the same port leaves the count unchanged.
  - A counter never wraps: eligibility blocks the increment at MaxOutstanding.
- Return path:
  - rsp_valid_o[p] = rd_valid_i & (port field of rd_id_i == p).
  - rsp_last_o, rsp_data_o and rsp_tid_o (low TidWidth bits of rd_id_i) are wired straight through.
  - Zero latency, no buffering.
- Error: a beat whose port has cnt == 0:
  - rsp_valid_o for that port is still suppressed.
  - err_o is set and stays set until reset.
  - No counter changes.
- busy_o = (state == HOLD) | (any cnt != 0).
- Reset mid-operation:
  - All state is cleared; in-flight bursts are forgotten.
  - Late beats for those bursts set err_o.

Optional Feature:
ICACHE_ARB_FIXED_PRIO_EN
- Defined: selection in IDLE is strict fixed priority, with port 0 highest; the pointer register is removed.
- Undefined: round-robin as specified above.
- HOLD behaviour and counters are identical in both modes.

Test Plan:
- Both ports request in the same cycle, pointer 0, rd_gnt_i tied 1 -> req_gnt_o = 01 in cycle 0; rd_id_o = {0, tid0}; port 1 granted in the next cycle; pointer returns to 0.
- Port 0 requests addr 0x8000_0040, rd_gnt_i held low for 3 cycles; port 1 raises req_i in cycle 1 -> rd_addr_o stays 0x8000_0040 throughout; grant goes to port 0 in cycle 3; port 1 granted afterwards.
- MaxOutstanding=2: port 0 issues 2 grants with no return -> third request is not granted; beat with rd_last_i=1 and port-0 ID -> next-cycle grant.
- 4-beat burst with rd_id_i = {1, 3'b101} -> rsp_valid_o = 10 on each beat; rsp_tid_o = 5; cnt[1] decrements only on the last beat.
- Grant on port 1 in the same cycle as a last beat for port 1 -> cnt[1] is unchanged; busy_o stays 1.
- Returned beat with port-0 ID while cnt[0]=0 -> rsp_valid_o = 00, err_o=1 sticky; reset clears err_o; with the macro defined, simultaneous requests always grant port 0 first.

Source files
------------

// File: rtl/icache_refill_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : icache_refill_arbiter
// Purpose  : Shares the single read channel of the I$ AXI shim between
//            NumPorts refill requesters (port 0: L1I$ miss/bypass path,
//            port 1: prefetcher / ISPM fill engine). A selected request is
//            held stable until the shim grants it. Outstanding bursts are
//            counted per port, and returning beats are steered back to their
//            owner using the port field in the upper bits of the AXI ID.
// Revision : 1.0 - initial release
//
// Ports
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   req_i / req_*_i           per-port request and its address/blen/size/tid
//   req_gnt_o                 one-hot grant pulse back to the requester
//   rsp_valid_o               per-port return beat valid
//   rsp_last_o/data_o/tid_o   broadcast return beat fields
//   rd_req_o .. rd_id_o       request side toward the shim
//   rd_gnt_i                  shim accepted the request
//   rd_rdy_o                  always ready for return beats
//   rd_valid_i .. rd_id_i     return beats from the shim
//   busy_o                    request held or any burst outstanding
//   err_o                     sticky: beat returned for a port with nothing
//                             outstanding
//
// Configuration macro
//   ICACHE_ARB_FIXED_PRIO_EN  defined: fixed priority (port 0 highest), no
//                             round-robin pointer. Undefined: round-robin.
// ============================================================================
module icache_refill_arbiter #(
  parameter  int NumPorts       = 2,
  parameter  int AddrWidth      = 64,
  parameter  int DataWidth      = 64,
  parameter  int IdWidth        = 4,
  parameter  int BlenWidth      = 2,
  parameter  int MaxOutstanding = 2,
  localparam int PortBits       = $clog2(NumPorts),
  localparam int TidWidth       = IdWidth - PortBits
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NumPorts-1:0]                 req_i,
  input  logic [NumPorts-1:0][AddrWidth-1:0]  req_addr_i,
  input  logic [NumPorts-1:0][BlenWidth-1:0]  req_blen_i,
  input  logic [NumPorts-1:0][2:0]            req_size_i,
  input  logic [NumPorts-1:0][TidWidth-1:0]   req_tid_i,
  output logic [NumPorts-1:0]                 req_gnt_o,
  output logic [NumPorts-1:0]                 rsp_valid_o,
  output logic                                rsp_last_o,
  output logic [DataWidth-1:0]                rsp_data_o,
  output logic [TidWidth-1:0]                 rsp_tid_o,
  output logic                                rd_req_o,
  input  logic                                rd_gnt_i,
  output logic [AddrWidth-1:0]                rd_addr_o,
  output logic [BlenWidth-1:0]                rd_blen_o,
  output logic [2:0]                          rd_size_o,
  output logic [IdWidth-1:0]                  rd_id_o,
  output logic                                rd_rdy_o,
  input  logic                                rd_valid_i,
  input  logic                                rd_last_i,
  input  logic [DataWidth-1:0]                rd_data_i,
  input  logic [IdWidth-1:0]                  rd_id_i,
  output logic                                busy_o,
  output logic                                err_o
);

  // Wide enough to hold MaxOutstanding itself.
  localparam int CntWidth = $clog2(MaxOutstanding + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t                             state;
  logic [PortBits-1:0]                held_port;
  logic [NumPorts-1:0][CntWidth-1:0]  cnt;

  logic [NumPorts-1:0]                eligible;
  logic                               sel_valid;
  logic [PortBits-1:0]                sel_port;
  logic [PortBits-1:0]                cur_port;
  logic [PortBits-1:0]                ret_port;
  logic                               grant;
  logic                               beat_ok;

  always_comb begin
    for (int p = 0; p < NumPorts; p++) begin
      eligible[p] = req_i[p] && (cnt[p] < CntWidth'(MaxOutstanding));
    end
  end

`ifdef ICACHE_ARB_FIXED_PRIO_EN
  // Descending scan so the lowest eligible index is the last one written.
  always_comb begin
    sel_valid = 1'b0;
    sel_port  = '0;
    for (int p = NumPorts - 1; p >= 0; p--) begin
      if (eligible[p]) begin
        sel_valid = 1'b1;
        sel_port  = PortBits'(p);
      end
    end
  end
`else
  logic [PortBits-1:0] rr_ptr;

  // Scan offsets from the pointer; PortBits-wide addition wraps modulo
  // NumPorts because NumPorts is a power of two. Descending scan leaves the
  // smallest offset as the winner.
  always_comb begin
    sel_valid = 1'b0;
    sel_port  = '0;
    for (int k = NumPorts - 1; k >= 0; k--) begin
      if (eligible[rr_ptr + PortBits'(k)]) begin
        sel_valid = 1'b1;
        sel_port  = rr_ptr + PortBits'(k);
      end
    end
  end
`endif

  // In HOLD the latched port owns the channel regardless of req_i or the
  // other ports, so the shim sees a stable request until it grants.
  assign cur_port = (state == HOLD) ? held_port : sel_port;
  assign rd_req_o = (state == HOLD) || sel_valid;
  assign grant    = rd_req_o && rd_gnt_i;

  assign rd_addr_o = rd_req_o ? req_addr_i[cur_port] : '0;
  assign rd_blen_o = rd_req_o ? req_blen_i[cur_port] : '0;
  assign rd_size_o = rd_req_o ? req_size_i[cur_port] : '0;
  assign rd_id_o   = rd_req_o ? {cur_port, req_tid_i[cur_port]} : '0;
  assign rd_rdy_o  = 1'b1;

  // Return path: a beat for a port with nothing outstanding is dropped.
  assign ret_port = rd_id_i[IdWidth-1 -: PortBits];
  assign beat_ok  = rd_valid_i && (cnt[ret_port] != '0);

  always_comb begin
    for (int p = 0; p < NumPorts; p++) begin
      req_gnt_o[p]   = grant && (cur_port == PortBits'(p));
      rsp_valid_o[p] = beat_ok && (ret_port == PortBits'(p));
    end
  end

  assign rsp_last_o = rd_last_i;
  assign rsp_data_o = rd_data_i;
  assign rsp_tid_o  = rd_id_i[TidWidth-1:0];
  assign busy_o     = (state == HOLD) || (|cnt);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      held_port <= '0;
      cnt       <= '0;
      err_o     <= 1'b0;
`ifndef ICACHE_ARB_FIXED_PRIO_EN
      rr_ptr    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (sel_valid && !rd_gnt_i) begin
            state     <= HOLD;
            held_port <= sel_port;
          end
        end
        HOLD: begin
          if (rd_gnt_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

`ifndef ICACHE_ARB_FIXED_PRIO_EN
      if (grant) begin
        rr_ptr <= cur_port + PortBits'(1);
      end
`endif

      if (rd_valid_i && (cnt[ret_port] == '0)) begin
        err_o <= 1'b1;
      end

      for (int p = 0; p < NumPorts; p++) begin
        if (req_gnt_o[p] && !(rsp_valid_o[p] && rd_last_i)) begin
          cnt[p] <= cnt[p] + CntWidth'(1);
        end else if (!req_gnt_o[p] && rsp_valid_o[p] && rd_last_i) begin
          cnt[p] <= cnt[p] - CntWidth'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_icache_refill_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_refill_arbiter
// Purpose  : Self-checking bench for icache_refill_arbiter: a directed vector
//            table, hand-written multi-cycle sequences, and a randomized run
//            compared against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_icache_refill_arbiter;

  localparam int NP = 2;
  localparam int MO = 2;
`ifdef ICACHE_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif
  localparam logic [63:0] A0 = 64'h8000_0040;
  localparam logic [63:0] A1 = 64'h9000_0080;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       req;
  logic [1:0][63:0] req_addr;
  logic [1:0][1:0]  req_blen;
  logic [1:0][2:0]  req_size;
  logic [1:0][2:0]  req_tid;
  logic [1:0]       gnt_o;
  logic [1:0]       rspv;
  logic             rsp_last;
  logic [63:0]      rsp_data;
  logic [2:0]       rsp_tid;
  logic             rd_req;
  logic             rd_gnt;
  logic [63:0]      rd_addr;
  logic [1:0]       rd_blen;
  logic [2:0]       rd_size;
  logic [3:0]       rd_id;
  logic             rd_rdy;
  logic             rv;
  logic             rl;
  logic [63:0]      rdata;
  logic [3:0]       rid;
  logic             busy;
  logic             err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  icache_refill_arbiter dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_i(req), .req_addr_i(req_addr), .req_blen_i(req_blen),
    .req_size_i(req_size), .req_tid_i(req_tid), .req_gnt_o(gnt_o),
    .rsp_valid_o(rspv), .rsp_last_o(rsp_last), .rsp_data_o(rsp_data),
    .rsp_tid_o(rsp_tid), .rd_req_o(rd_req), .rd_gnt_i(rd_gnt),
    .rd_addr_o(rd_addr), .rd_blen_o(rd_blen), .rd_size_o(rd_size),
    .rd_id_o(rd_id), .rd_rdy_o(rd_rdy), .rd_valid_i(rv), .rd_last_i(rl),
    .rd_data_i(rdata), .rd_id_i(rid), .busy_o(busy), .err_o(err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    req = '0; rd_gnt = 1'b0; rv = 1'b0; rl = 1'b0; rid = '0; rdata = '0;
    req_addr[0] = A0; req_addr[1] = A1;
    req_blen[0] = 2'd3; req_blen[1] = 2'd1;
    req_size[0] = 3'd3; req_size[1] = 3'd2;
    req_tid[0] = 3'b010; req_tid[1] = 3'b101;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0]  req;
    logic        gnt;
    logic        rv;
    logic        rl;
    logic [3:0]  rid;
    logic [1:0]  e_gnt;
    logic        e_rdreq;
    logic [3:0]  e_id;
    logic [63:0] e_addr;
    logic [1:0]  e_rspv;
    logic        e_busy;
    logic        e_err;
  } vec_t;

  vec_t tbl[14];

  task automatic run_table();
    tbl[0]  = '{2'b00, 1'b0, 1'b0, 1'b0, 4'h0, 2'b00, 1'b0, 4'h0, 64'h0, 2'b00, 1'b0, 1'b0};
    tbl[1]  = '{2'b01, 1'b0, 1'b0, 1'b0, 4'h0, 2'b00, 1'b1, 4'h2, A0,    2'b00, 1'b0, 1'b0};
    tbl[2]  = '{2'b11, 1'b0, 1'b0, 1'b0, 4'h0, 2'b00, 1'b1, 4'h2, A0,    2'b00, 1'b1, 1'b0};
    tbl[3]  = '{2'b11, 1'b0, 1'b0, 1'b0, 4'h0, 2'b00, 1'b1, 4'h2, A0,    2'b00, 1'b1, 1'b0};
    tbl[4]  = '{2'b11, 1'b1, 1'b0, 1'b0, 4'h0, 2'b01, 1'b1, 4'h2, A0,    2'b00, 1'b1, 1'b0};
    tbl[5]  = '{2'b10, 1'b1, 1'b0, 1'b0, 4'h0, 2'b10, 1'b1, 4'hD, A1,    2'b00, 1'b1, 1'b0};
    tbl[6]  = '{2'b00, 1'b0, 1'b1, 1'b1, 4'h2, 2'b00, 1'b0, 4'h0, 64'h0, 2'b01, 1'b1, 1'b0};
    tbl[7]  = '{2'b00, 1'b0, 1'b1, 1'b0, 4'hD, 2'b00, 1'b0, 4'h0, 64'h0, 2'b10, 1'b1, 1'b0};
    tbl[8]  = '{2'b00, 1'b0, 1'b1, 1'b0, 4'hD, 2'b00, 1'b0, 4'h0, 64'h0, 2'b10, 1'b1, 1'b0};
    tbl[9]  = '{2'b00, 1'b0, 1'b1, 1'b0, 4'hD, 2'b00, 1'b0, 4'h0, 64'h0, 2'b10, 1'b1, 1'b0};
    tbl[10] = '{2'b00, 1'b0, 1'b1, 1'b1, 4'hD, 2'b00, 1'b0, 4'h0, 64'h0, 2'b10, 1'b1, 1'b0};
    tbl[11] = '{2'b00, 1'b0, 1'b0, 1'b0, 4'h0, 2'b00, 1'b0, 4'h0, 64'h0, 2'b00, 1'b0, 1'b0};
    tbl[12] = '{2'b00, 1'b0, 1'b1, 1'b0, 4'h2, 2'b00, 1'b0, 4'h0, 64'h0, 2'b00, 1'b0, 1'b0};
    tbl[13] = '{2'b00, 1'b0, 1'b0, 1'b0, 4'h0, 2'b00, 1'b0, 4'h0, 64'h0, 2'b00, 1'b0, 1'b1};
    for (int i = 0; i < 14; i++) begin
      req = tbl[i].req; rd_gnt = tbl[i].gnt; rv = tbl[i].rv; rl = tbl[i].rl;
      rid = tbl[i].rid; rdata = 64'hDEAD_BEEF_0000_0000 + 64'(i);
      #1;
      chk($sformatf("tbl%0d gnt", i), gnt_o, tbl[i].e_gnt);
      chk($sformatf("tbl%0d rd_req", i), rd_req, tbl[i].e_rdreq);
      chk($sformatf("tbl%0d rd_id", i), rd_id, tbl[i].e_id);
      chk($sformatf("tbl%0d rd_addr", i), rd_addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d rsp_valid", i), rspv, tbl[i].e_rspv);
      chk($sformatf("tbl%0d busy", i), busy, tbl[i].e_busy);
      chk($sformatf("tbl%0d err", i), err, tbl[i].e_err);
      chk($sformatf("tbl%0d rsp_data", i), rsp_data, rdata);
      if (tbl[i].rv) chk($sformatf("tbl%0d rsp_tid", i), rsp_tid, {61'd0, tbl[i].rid[2:0]});
      tick();
    end
  endtask

  // ---------------- reference model ----------------
  int m_cnt[NP];
  bit m_hold;
  int m_held;
  int m_ptr;
  bit m_err;

  task automatic model_reset();
    for (int p = 0; p < NP; p++) m_cnt[p] = 0;
    m_hold = 0; m_held = 0; m_ptr = 0; m_err = 0;
  endtask

  task automatic run_random(input int ncyc);
    int p, q, rp, tot;
    bit rq, ok_beat;
    logic [1:0] e_gnt, e_rspv;
    logic [3:0] e_id;
    model_reset();
    for (int c = 0; c < ncyc; c++) begin
      if (c == ncyc / 2) begin
        // Mid-operation reset: model forgets all in-flight bursts.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_reset();
      end
      req = 2'($urandom);
      rd_gnt = ($urandom % 3) != 0;
      for (int k = 0; k < NP; k++) begin
        req_addr[k] = {$urandom, $urandom};
        req_blen[k] = 2'($urandom);
        req_size[k] = 3'($urandom);
        req_tid[k]  = 3'($urandom);
      end
      rv = 1'($urandom); rl = 1'($urandom); rdata = {$urandom, $urandom};
      tot = m_cnt[0] + m_cnt[1];
      if (($urandom % 10) != 0 && tot > 0)
        rp = (m_cnt[0] > 0 && (m_cnt[1] == 0 || $urandom % 2 == 0)) ? 0 : 1;
      else
        rp = $urandom % 2;
      rid = {1'(rp), 3'($urandom)};
      #1;
      // Expected outputs from the current model state.
      p = -1;
      if (m_hold) p = m_held;
      else begin
        for (int k = 0; k < NP; k++) begin
          q = FIXED ? k : (m_ptr + k) % NP;
          if (p < 0 && req[q] && m_cnt[q] < MO) p = q;
        end
      end
      rq = (p >= 0);
      e_gnt = (rq && rd_gnt) ? 2'(1 << p) : 2'b00;
      e_id  = rq ? 4'(p * 8 + int'(req_tid[p])) : 4'h0;
      rp = int'(rid[3]);
      ok_beat = rv && m_cnt[rp] > 0;
      e_rspv = ok_beat ? 2'(1 << rp) : 2'b00;
      chk("rnd gnt", gnt_o, e_gnt);
      chk("rnd rd_req", rd_req, rq);
      chk("rnd rd_id", rd_id, e_id);
      chk("rnd rd_addr", rd_addr, rq ? req_addr[p] : 64'h0);
      chk("rnd rd_blen", rd_blen, rq ? req_blen[p] : 2'b00);
      chk("rnd rd_size", rd_size, rq ? req_size[p] : 3'b000);
      chk("rnd rsp_valid", rspv, e_rspv);
      chk("rnd rsp_tid", rsp_tid, rid[2:0]);
      chk("rnd rsp_last", rsp_last, rl);
      chk("rnd rsp_data", rsp_data, rdata);
      chk("rnd busy", busy, m_hold || (m_cnt[0] + m_cnt[1]) > 0);
      chk("rnd err", err, m_err);
      chk("rnd rd_rdy", rd_rdy, 1'b1);
      // Advance the model.
      if (rv && m_cnt[rp] == 0) m_err = 1;
      if (ok_beat && rl) m_cnt[rp]--;
      if (rq && rd_gnt) begin
        m_cnt[p]++;
        m_ptr = (p + 1) % NP;
        m_hold = 0;
      end else if (rq) begin
        m_hold = 1;
        m_held = p;
      end
      tick();
    end
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("reset busy", busy, 1'b0);
    chk("reset err", err, 1'b0);
    chk("reset rd_req", rd_req, 1'b0);
    chk("reset rd_rdy", rd_rdy, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    run_table();

    // Reset clears the sticky error left by the table.
    do_reset();
    #1;
    chk("err cleared", err, 1'b0);

    // Both ports requesting with an always-granting shim.
    req = 2'b11; rd_gnt = 1'b1; #1;
    chk("both c0 gnt", gnt_o, 2'b01);
    chk("both c0 id", rd_id, 4'h2);
    tick(); #1;
    chk("both c1 gnt", gnt_o, FIXED ? 2'b01 : 2'b10);
    chk("both c1 id", rd_id, FIXED ? 4'h2 : 4'hD);
    tick(); #1;
    chk("both c2 gnt", gnt_o, FIXED ? 2'b10 : 2'b01);

    // Outstanding limit on port 0, released by a last beat.
    do_reset();
    req = 2'b01; rd_gnt = 1'b1;
    #1; chk("max g1", gnt_o, 2'b01); tick();
    #1; chk("max g2", gnt_o, 2'b01); tick();
    #1; chk("max blocked gnt", gnt_o, 2'b00); chk("max blocked rd_req", rd_req, 1'b0); tick();
    rv = 1'b1; rl = 1'b1; rid = 4'h2;
    #1; chk("max ret gnt", gnt_o, 2'b00); chk("max ret rspv", rspv, 2'b01); tick();
    rv = 1'b0; rl = 1'b0;
    #1; chk("max regrant", gnt_o, 2'b01); tick();

    // Grant and last beat on port 1 in the same cycle.
    do_reset();
    req = 2'b10; rd_gnt = 1'b1;
    #1; chk("sim g1", gnt_o, 2'b10); tick();
    rv = 1'b1; rl = 1'b1; rid = 4'hD;
    #1; chk("sim g2", gnt_o, 2'b10); chk("sim rspv", rspv, 2'b10); tick();
    req = 2'b00; rv = 1'b0; rl = 1'b0;
    #1; chk("sim busy held", busy, 1'b1); tick();
    rv = 1'b1; rl = 1'b1; rid = 4'hD;
    #1; chk("sim final rspv", rspv, 2'b10); tick();
    rv = 1'b0; rl = 1'b0;
    #1; chk("sim busy clear", busy, 1'b0);

    do_reset();
    run_random(3000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
